// File: rtl/load_store_unit_if.sv
// Request/response and data-memory bus between the MIPS memory stage and the LSU.
// slave = LSU side, master = pipeline plus memory side.
interface load_store_unit_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              reqValid;
    logic              reqReady;
    logic              reqWrite;
    logic [1:0]        reqSize;
    logic              reqSigned;
    logic [ADDR_W-1:0] reqAddr;
    logic [DATA_W-1:0] reqData;
    logic              respValid;
    logic [DATA_W-1:0] respData;
    logic              misaligned;
    logic [ADDR_W-1:0] memAddress;
    logic [DATA_W-1:0] memWriteData;
    logic              memRead;
    logic              memWrite;
    logic [DATA_W-1:0] memReadData;

    modport slave (
        input  reqValid, reqWrite, reqSize, reqSigned, reqAddr, reqData, memReadData,
        output reqReady, respValid, respData, misaligned,
        output memAddress, memWriteData, memRead, memWrite
    );

    modport master (
        output reqValid, reqWrite, reqSize, reqSigned, reqAddr, reqData, memReadData,
        input  reqReady, respValid, respData, misaligned,
        input  memAddress, memWriteData, memRead, memWrite
    );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit: byte/half/word access to a word-wide memory, sub-word stores by read-modify-write.
// Latency acceptance->respValid: error 1, load 2, word store 2, sub-word store 4.
// Backpressure: one request in flight, reqReady high only in IDLE.
module load_store_unit #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    load_store_unit_if.slave  bus
);
    typedef enum logic [2:0] {IDLE, RD, RMW_RD, GAP, WR, RESP} state_t;

    state_t state, state_n;
    logic   req_err;

    logic [1:0]        addr_q;
    logic [1:0]        size_q;
    logic              sgn_q;
    logic [15:0]       sdata_q;
    logic [DATA_W-1:0] rdata_q;

    logic              req_ready_q;
    logic              resp_valid_q;
    logic [DATA_W-1:0] resp_data_q;
    logic              misaligned_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;
    logic              mem_read_q;
    logic              mem_write_q;

    function automatic logic [DATA_W-1:0] extract(input logic [DATA_W-1:0] w, input logic [1:0] a,
                                                  input logic [1:0] sz, input logic sgn);
        logic [7:0]  b;
        logic [15:0] h;
        b = w[{a, 3'b000} +: 8];
        h = a[1] ? w[31:16] : w[15:0];
        case (sz)
            2'd0:    return {{24{sgn & b[7]}}, b};
            2'd1:    return {{16{sgn & h[15]}}, h};
            default: return w;
        endcase
    endfunction

    function automatic logic [DATA_W-1:0] merge(input logic [DATA_W-1:0] w, input logic [1:0] a,
                                                input logic [1:0] sz, input logic [15:0] d);
        logic [DATA_W-1:0] r;
        r = w;
        if (sz == 2'd0)
            r[{a, 3'b000} +: 8] = d[7:0];
        else if (a[1])
            r[31:16] = d;
        else
            r[15:0] = d;
        return r;
    endfunction

    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (bus.reqSize)
            2'd0:    req_err = 1'b0;
            2'd1:    req_err = bus.reqAddr[0];
            2'd2:    req_err = |bus.reqAddr[1:0];
            default: req_err = 1'b1;
        endcase
        case (state)
            IDLE: begin
                if (bus.reqValid) begin
                    if (req_err)
                        state_n = RESP;
                    else if (!bus.reqWrite)
                        state_n = RD;
                    else if (bus.reqSize == 2'd2)
                        state_n = WR;
                    else
                        state_n = RMW_RD;
                end
            end
            RD:      state_n = RESP;
            RMW_RD:  state_n = GAP;
            GAP:     state_n = WR;
            WR:      state_n = RESP;
            RESP:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Strobes/handshake are registered from the next state so every output is a flop.
    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q       <= '0;
            size_q       <= '0;
            sgn_q        <= 1'b0;
            sdata_q      <= '0;
            rdata_q      <= '0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_data_q  <= '0;
            misaligned_q <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
        end else begin
            req_ready_q  <= (state_n == IDLE);
            resp_valid_q <= (state_n == RESP);
            mem_read_q   <= (state_n == RD) || (state_n == RMW_RD);
            mem_write_q  <= (state_n == WR);
            case (state)
                IDLE: begin
                    if (bus.reqValid) begin
                        addr_q  <= bus.reqAddr[1:0];
                        size_q  <= bus.reqSize;
                        sgn_q   <= bus.reqSigned;
                        sdata_q <= bus.reqData[15:0];
                        if (req_err) begin
                            resp_data_q  <= '0;
                            misaligned_q <= 1'b1;
                        end else begin
                            mem_addr_q <= {bus.reqAddr[ADDR_W-1:2], 2'b00};
                            if (bus.reqWrite && bus.reqSize == 2'd2)
                                mem_wdata_q <= bus.reqData;
                        end
                    end
                end
                RD: begin
                    resp_data_q  <= extract(bus.memReadData, addr_q, size_q, sgn_q);
                    misaligned_q <= 1'b0;
                end
                RMW_RD: rdata_q     <= bus.memReadData;
                GAP:    mem_wdata_q <= merge(rdata_q, addr_q, size_q, sdata_q);
                WR: begin
                    resp_data_q  <= '0;
                    misaligned_q <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign bus.reqReady     = req_ready_q;
    assign bus.respValid    = resp_valid_q;
    assign bus.respData     = resp_data_q;
    assign bus.misaligned   = misaligned_q;
    assign bus.memAddress   = mem_addr_q;
    assign bus.memWriteData = mem_wdata_q;
    assign bus.memRead      = mem_read_q;
    assign bus.memWrite     = mem_write_q;
endmodule

// File: tb/tb_load_store_unit.sv
// Directed vector bench for load_store_unit with a small word memory model.
module tb_load_store_unit;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    load_store_unit_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    load_store_unit #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    logic [31:0] mem [0:63];
    always @(posedge clk)
        if (bus.memWrite) mem[bus.memAddress[7:2]] <= bus.memWriteData;
    assign bus.memReadData = bus.memRead ? mem[bus.memAddress[7:2]] : 32'h0;

    typedef struct {
        logic        wr;
        logic [1:0]  sz;
        logic        sgn;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] exp_resp;
        logic        exp_mis;
        int          exp_lat;
        int          exp_rd;
        int          exp_wr;
        logic        chk_mem;
        logic [31:0] exp_mem;
    } vec_t;

    vec_t vt[$];
    int n_cmp = 0;
    int n_err = 0;

    function automatic vec_t mk(logic wr, logic [1:0] sz, logic sgn, logic [31:0] addr, logic [31:0] data,
                                logic [31:0] resp, logic mis, int lat, int rd, int wrn,
                                logic cm, logic [31:0] em);
        vec_t v;
        v.wr = wr; v.sz = sz; v.sgn = sgn; v.addr = addr; v.data = data;
        v.exp_resp = resp; v.exp_mis = mis; v.exp_lat = lat; v.exp_rd = rd; v.exp_wr = wrn;
        v.chk_mem = cm; v.exp_mem = em;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", nm, act, exp);
        end
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int   guard, lat, nrd, nwr, nov, ngap, nalign;
        logic prev, cur;
        guard = 0;
        while (!bus.reqReady && guard < 20) begin
            @(posedge clk); #1;
            guard++;
        end
        chk($sformatf("v%0d ready", idx), {31'd0, bus.reqReady}, 32'd1);
        bus.reqValid  = 1'b1;
        bus.reqWrite  = v.wr;
        bus.reqSize   = v.sz;
        bus.reqSigned = v.sgn;
        bus.reqAddr   = v.addr;
        bus.reqData   = v.data;
        @(posedge clk); #1;
        // Scramble inputs: the LSU must work from its registered copy.
        bus.reqValid  = 1'b0;
        bus.reqWrite  = ~v.wr;
        bus.reqSize   = 2'd3;
        bus.reqSigned = ~v.sgn;
        bus.reqAddr   = 32'hFFFF_FFFF;
        bus.reqData   = 32'h5555_5555;
        chk($sformatf("v%0d busy", idx), {31'd0, bus.reqReady}, 32'd0);
        lat = 0; nrd = 0; nwr = 0; nov = 0; ngap = 0; nalign = 0; prev = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            cur = bus.memRead | bus.memWrite;
            if (bus.memRead) nrd++;
            if (bus.memWrite) nwr++;
            if (bus.memRead && bus.memWrite) nov++;
            if (cur && prev) ngap++;
            if (cur && bus.memAddress[1:0] != 2'b00) nalign++;
            prev = cur;
            if (bus.respValid) begin
                lat = c;
                break;
            end
            @(posedge clk); #1;
        end
        chk($sformatf("v%0d latency", idx), lat, v.exp_lat);
        chk($sformatf("v%0d respData", idx), bus.respData, v.exp_resp);
        chk($sformatf("v%0d misaligned", idx), {31'd0, bus.misaligned}, {31'd0, v.exp_mis});
        chk($sformatf("v%0d reads", idx), nrd, v.exp_rd);
        chk($sformatf("v%0d writes", idx), nwr, v.exp_wr);
        chk($sformatf("v%0d overlap", idx), nov, 0);
        chk($sformatf("v%0d gap", idx), ngap, 0);
        chk($sformatf("v%0d align", idx), nalign, 0);
        if (v.chk_mem)
            chk($sformatf("v%0d mem", idx), mem[v.addr[7:2]], v.exp_mem);
        @(posedge clk); #1;
        chk($sformatf("v%0d pulse", idx), {31'd0, bus.respValid}, 32'd0);
        chk($sformatf("v%0d hold", idx), bus.respData, v.exp_resp);
    endtask

    initial begin
        int nrv, nrd, nwr, ngap, nbad;
        logic prev, cur;

        //      wr sz sgn addr      data          resp          mis lat rd wr cm  mem
        vt.push_back(mk(1, 2, 0, 32'h10, 32'hDEADBEEF, 32'h0,        0, 2, 0, 1, 1, 32'hDEADBEEF));
        vt.push_back(mk(0, 2, 0, 32'h10, 32'h0,        32'hDEADBEEF, 0, 2, 1, 0, 0, 32'h0));
        vt.push_back(mk(1, 2, 0, 32'h20, 32'h11223344, 32'h0,        0, 2, 0, 1, 1, 32'h11223344));
        vt.push_back(mk(1, 0, 0, 32'h22, 32'h000000AA, 32'h0,        0, 4, 1, 1, 1, 32'h11AA3344));
        vt.push_back(mk(1, 1, 0, 32'h20, 32'h0000BEEF, 32'h0,        0, 4, 1, 1, 1, 32'h11AABEEF));
        vt.push_back(mk(1, 2, 0, 32'h30, 32'h80FF7F01, 32'h0,        0, 2, 0, 1, 1, 32'h80FF7F01));
        vt.push_back(mk(0, 2, 1, 32'h30, 32'h0,        32'h80FF7F01, 0, 2, 1, 0, 0, 32'h0));
        vt.push_back(mk(0, 0, 1, 32'h31, 32'h0,        32'h0000007F, 0, 2, 1, 0, 0, 32'h0));
        vt.push_back(mk(0, 0, 1, 32'h32, 32'h0,        32'hFFFFFFFF, 0, 2, 1, 0, 0, 32'h0));
        vt.push_back(mk(0, 0, 0, 32'h32, 32'h0,        32'h000000FF, 0, 2, 1, 0, 0, 32'h0));
        vt.push_back(mk(0, 1, 1, 32'h32, 32'h0,        32'hFFFF80FF, 0, 2, 1, 0, 0, 32'h0));
        vt.push_back(mk(0, 1, 0, 32'h32, 32'h0,        32'h000080FF, 0, 2, 1, 0, 0, 32'h0));
        vt.push_back(mk(0, 2, 0, 32'h13, 32'h0,        32'h0,        1, 1, 0, 0, 0, 32'h0));
        vt.push_back(mk(1, 1, 0, 32'h21, 32'h00001234, 32'h0,        1, 1, 0, 0, 1, 32'h11AABEEF));
        vt.push_back(mk(0, 3, 0, 32'h40, 32'h0,        32'h0,        1, 1, 0, 0, 0, 32'h0));
        vt.push_back(mk(1, 0, 1, 32'h33, 32'h0000005A, 32'h0,        0, 4, 1, 1, 1, 32'h5AFF7F01));
        vt.push_back(mk(1, 0, 0, 32'h31, 32'hFFFFFF12, 32'h0,        0, 4, 1, 1, 1, 32'h5AFF1201));
        vt.push_back(mk(1, 1, 0, 32'h30, 32'h00009234, 32'h0,        0, 4, 1, 1, 1, 32'h5AFF9234));
        vt.push_back(mk(0, 1, 1, 32'h30, 32'h0,        32'hFFFF9234, 0, 2, 1, 0, 0, 32'h0));
        vt.push_back(mk(0, 0, 1, 32'h33, 32'h0,        32'h0000005A, 0, 2, 1, 0, 0, 32'h0));
        vt.push_back(mk(0, 1, 0, 32'h32, 32'h0,        32'h00005AFF, 0, 2, 1, 0, 0, 32'h0));

        bus.reqValid = 1'b0; bus.reqWrite = 1'b0; bus.reqSize = 2'd0; bus.reqSigned = 1'b0;
        bus.reqAddr = 32'h0; bus.reqData = 32'h0;

        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst reqReady",     {31'd0, bus.reqReady},   32'd1);
        chk("rst respValid",    {31'd0, bus.respValid},  32'd0);
        chk("rst respData",     bus.respData,            32'd0);
        chk("rst misaligned",   {31'd0, bus.misaligned}, 32'd0);
        chk("rst memRead",      {31'd0, bus.memRead},    32'd0);
        chk("rst memWrite",     {31'd0, bus.memWrite},   32'd0);
        chk("rst memAddress",   bus.memAddress,          32'd0);
        chk("rst memWriteData", bus.memWriteData,        32'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        foreach (vt[i]) run_vec(i, vt[i]);

        // Reset during GAP of a sub-word store: memory word 0x20 must stay 0x11AABEEF.
        bus.reqValid = 1'b1; bus.reqWrite = 1'b1; bus.reqSize = 2'd0; bus.reqSigned = 1'b0;
        bus.reqAddr = 32'h22; bus.reqData = 32'h00000055;
        @(posedge clk); #1;
        bus.reqValid = 1'b0;
        chk("abort rmw read", {31'd0, bus.memRead}, 32'd1);
        @(posedge clk); #1;
        chk("abort gap idle", {31'd0, bus.memRead | bus.memWrite}, 32'd0);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("abort reqReady", {31'd0, bus.reqReady}, 32'd1);
        nrv = 0; nwr = 0;
        for (int c = 0; c < 5; c++) begin
            if (bus.respValid) nrv++;
            if (bus.memWrite) nwr++;
            @(posedge clk); #1;
        end
        chk("abort writes", nwr, 0);
        chk("abort resp", nrv, 0);
        chk("abort mem", mem[8], 32'h11AABEEF);

        // Back-to-back loads with reqValid held: IDLE/RD/RESP repeating.
        bus.reqValid = 1'b1; bus.reqWrite = 1'b0; bus.reqSize = 2'd2; bus.reqSigned = 1'b0;
        bus.reqAddr = 32'h10; bus.reqData = 32'h0;
        nrv = 0; nrd = 0; ngap = 0; nbad = 0; prev = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            @(posedge clk); #1;
            cur = bus.memRead | bus.memWrite;
            if (cur && prev) ngap++;
            prev = cur;
            if (bus.memRead) nrd++;
            if (bus.respValid) begin
                nrv++;
                if (bus.respData !== 32'hDEADBEEF) nbad++;
            end
        end
        bus.reqValid = 1'b0;
        chk("b2b resp count", nrv, 4);
        chk("b2b read count", nrd, 4);
        chk("b2b gap", ngap, 0);
        chk("b2b data", nbad, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end
endmodule
